// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - instruction fetch stage with BIOS boot, hand-off, halt and redirect
//
// Drives pc into the BIOS ROM (BOOT) and main instruction memory (RUN/HALT),
// holds the instruction register presented to decode with a valido/pronto
// handshake, and sequences BOOT -> RUN -> HALT.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low
//   pc               registered fetch address to both memories
//   instrucao_bios   BIOS ROM word at pc (combinational)
//   instrucao_mem    main memory word at pc (combinational)
//   modo_bios        1 while fetching from BIOS
//   saida_instrucao  instruction register to decode
//   saida_pc         address of the instruction in saida_instrucao
//   valido           saida_instrucao is valid
//   pronto           decode accepts saida_instrucao this cycle
//   desvio           redirect request pulse from execute
//   alvo_desvio      redirect target
//   continuar        resume pulse after a main-program halt
//   parado           1 while halted

module unidade_busca #(
    parameter int                     PC_WIDTH    = 26,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [5:0]             HALT_OPCODE = 6'b011000
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instrucao_bios,
    input  logic [31:0]         instrucao_mem,
    output logic                modo_bios,
    output logic [31:0]         saida_instrucao,
    output logic [PC_WIDTH-1:0] saida_pc,
    output logic                valido,
    input  logic                pronto,
    input  logic                desvio,
    input  logic [PC_WIDTH-1:0] alvo_desvio,
    input  logic                continuar,
    output logic                parado
);

    localparam logic [PC_WIDTH-1:0] PC_UM = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } estado_t;

    estado_t estado;
    estado_t proximo;

    logic [31:0] instrucao;
    logic        eh_halt;
    logic        avanca;
    logic        busca;

    assign instrucao = modo_bios ? instrucao_bios : instrucao_mem;
    assign eh_halt   = (instrucao[31:26] == HALT_OPCODE);
    assign avanca    = (!valido || pronto) && (estado != HALT);
    // A redirect takes the cycle: no fetch happens alongside it.
    assign busca     = avanca && !desvio;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= BOOT;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic
    always_comb begin
        proximo = estado;
        case (estado)
            BOOT:    if (busca && eh_halt) proximo = RUN;
            RUN:     if (busca && eh_halt) proximo = HALT;
            HALT:    if (continuar)        proximo = RUN;
            default: proximo = BOOT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        modo_bios = (estado == BOOT);
        parado    = (estado == HALT);
    end

    // Fetch datapath: pc and instruction register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc              <= RESET_PC;
            saida_instrucao <= '0;
            saida_pc        <= '0;
            valido          <= 1'b0;
        end else if (estado == HALT) begin
            // pc frozen; the delivered halt drains to decode, redirects ignored.
            if (pronto) valido <= 1'b0;
        end else if (desvio) begin
            pc     <= alvo_desvio;
            valido <= 1'b0;
        end else if (avanca) begin
            if (modo_bios && eh_halt) begin
                // BIOS halt is a hand-off marker, never seen by decode.
                pc <= '0;
                if (pronto) valido <= 1'b0;
            end else begin
                saida_instrucao <= instrucao;
                saida_pc        <= pc;
                valido          <= 1'b1;
                pc              <= pc + PC_UM;
            end
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - scoreboard bench for the fetch stage
module tb_unidade_busca;

    localparam int PCW = 26;
    localparam logic [31:0] HALT_WORD = 32'h6000_0000;

    logic            clock = 1'b0;
    logic            reset;
    logic [PCW-1:0]  pc;
    logic [31:0]     instrucao_bios;
    logic [31:0]     instrucao_mem;
    logic            modo_bios;
    logic [31:0]     saida_instrucao;
    logic [PCW-1:0]  saida_pc;
    logic            valido;
    logic            pronto;
    logic            desvio;
    logic [PCW-1:0]  alvo_desvio;
    logic            continuar;
    logic            parado;

    int total  = 0;
    int passou = 0;

    typedef struct {
        logic [PCW-1:0] addr;
        logic [31:0]    instr;
    } esperado_t;

    esperado_t fila[$];

    always #5 clock = ~clock;

    unidade_busca #(.PC_WIDTH(PCW)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .instrucao_bios  (instrucao_bios),
        .instrucao_mem   (instrucao_mem),
        .modo_bios       (modo_bios),
        .saida_instrucao (saida_instrucao),
        .saida_pc        (saida_pc),
        .valido          (valido),
        .pronto          (pronto),
        .desvio          (desvio),
        .alvo_desvio     (alvo_desvio),
        .continuar       (continuar),
        .parado          (parado)
    );

    // 18-word BIOS image: words 0..16 ordinary, word 17 halt; beyond returns last word.
    function automatic logic [31:0] bios_word(input logic [PCW-1:0] a);
        if (a >= 26'd17) return HALT_WORD;
        return {6'b000100, a};
    endfunction

    // Main memory: addi-like words everywhere, halt at address 3.
    function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
        if (a == 26'd3) return HALT_WORD;
        return {6'b001000, a};
    endfunction

    assign instrucao_bios = bios_word(pc);
    assign instrucao_mem  = mem_word(pc);

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            passou++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_bios(input int a);
        esperado_t e;
        e.addr  = PCW'(a);
        e.instr = bios_word(PCW'(a));
        fila.push_back(e);
    endtask

    task automatic push_mem(input logic [PCW-1:0] a);
        esperado_t e;
        e.addr  = a;
        e.instr = mem_word(a);
        fila.push_back(e);
    endtask

    // Consumer side: every handshake decode completes must match the next expectation.
    always @(negedge clock) begin
        if (reset && valido && pronto) begin
            if (fila.size() == 0) begin
                verifica("sb_inesperado_pc", 32'(saida_pc), 32'hFFFF_FFFF);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                verifica("sb_pc", 32'(saida_pc), 32'(e.addr));
                verifica("sb_instr", saida_instrucao, e.instr);
            end
        end
    end

    initial begin
        int n;
        reset       = 1'b1;
        pronto      = 1'b1;
        desvio      = 1'b0;
        alvo_desvio = '0;
        continuar   = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        verifica("rst_pc", 32'(pc), 32'd0);
        verifica("rst_modo", 32'(modo_bios), 32'd1);
        verifica("rst_parado", 32'(parado), 32'd0);
        verifica("rst_valido", 32'(valido), 32'd0);
        verifica("rst_instr", saida_instrucao, 32'd0);
        verifica("rst_spc", 32'(saida_pc), 32'd0);

        // Boot from BIOS, hand off, run main program to halt.
        for (int i = 0; i < 17; i++) push_bios(i);
        for (int i = 0; i < 4; i++) push_mem(PCW'(i));
        reset = 1'b1;
        n = 0;
        while (modo_bios && n < 40) begin tick(); n++; end
        verifica("handoff_modo", 32'(modo_bios), 32'd0);
        verifica("handoff_pc", 32'(pc), 32'd0);
        verifica("handoff_valido", 32'(valido), 32'd0);

        n = 0;
        while (!parado && n < 20) begin tick(); n++; end
        verifica("halt_parado", 32'(parado), 32'd1);
        verifica("halt_pc", 32'(pc), 32'd4);
        repeat (10) tick();
        verifica("halt_hold_parado", 32'(parado), 32'd1);
        verifica("halt_hold_pc", 32'(pc), 32'd4);
        verifica("halt_drained", 32'(valido), 32'd0);

        // Resume, then backpressure at saida_pc=5.
        for (int i = 4; i < 8; i++) push_mem(PCW'(i));
        continuar = 1'b1;
        tick();
        continuar = 1'b0;
        verifica("resume_parado", 32'(parado), 32'd0);
        verifica("resume_pc", 32'(pc), 32'd4);
        n = 0;
        while (!(valido && saida_pc == 26'd5) && n < 10) begin tick(); n++; end
        pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            verifica("stall_spc", 32'(saida_pc), 32'd5);
            verifica("stall_pc", 32'(pc), 32'd6);
            verifica("stall_valido", 32'(valido), 32'd1);
            verifica("stall_instr", saida_instrucao, mem_word(26'd5));
        end
        pronto = 1'b1;

        // Redirect in RUN at pc=9; the in-flight word 8 is held then flushed.
        n = 0;
        while (pc != 26'd9 && n < 10) begin tick(); n++; end
        pronto      = 1'b0;
        desvio      = 1'b1;
        alvo_desvio = 26'h40;
        tick();
        desvio = 1'b0;
        pronto = 1'b1;
        verifica("desvio_valido", 32'(valido), 32'd0);
        verifica("desvio_pc", 32'(pc), 32'h40);
        push_mem(26'h40);
        tick();
        verifica("desvio_spc", 32'(saida_pc), 32'h40);

        // Wrap: jump to the last address.
        desvio      = 1'b1;
        alvo_desvio = 26'h3FF_FFFF;
        tick();
        desvio = 1'b0;
        verifica("wrap_pre_pc", 32'(pc), 32'h3FF_FFFF);
        push_mem(26'h3FF_FFFF);
        tick();
        verifica("wrap_spc", 32'(saida_pc), 32'h3FF_FFFF);
        verifica("wrap_pc", 32'(pc), 32'd0);

        // Asynchronous reset between clocks with valido=1.
        tick();
        verifica("mid_valido_pre", 32'(valido), 32'd1);
        #2 reset = 1'b0;
        #1;
        verifica("async_valido", 32'(valido), 32'd0);
        verifica("async_pc", 32'(pc), 32'd0);
        verifica("async_modo", 32'(modo_bios), 32'd1);
        verifica("sb_pendente", 32'(fila.size()), 32'd0);
        tick();

        // Restart from BIOS with an immediate redirect to BIOS word 15.
        push_bios(15);
        push_bios(16);
        for (int i = 0; i < 4; i++) push_mem(PCW'(i));
        reset       = 1'b1;
        desvio      = 1'b1;
        alvo_desvio = 26'd15;
        tick();
        desvio = 1'b0;
        verifica("boot_desvio_pc", 32'(pc), 32'd15);
        verifica("boot_desvio_modo", 32'(modo_bios), 32'd1);
        verifica("boot_desvio_valido", 32'(valido), 32'd0);
        n = 0;
        while (modo_bios && n < 20) begin tick(); n++; end
        verifica("boot2_modo", 32'(modo_bios), 32'd0);
        verifica("boot2_pc", 32'(pc), 32'd0);
        n = 0;
        while (!parado && n < 20) begin tick(); n++; end
        verifica("halt2_pc", 32'(pc), 32'd4);

        // continuar and desvio together in HALT: continuar wins.
        continuar   = 1'b1;
        desvio      = 1'b1;
        alvo_desvio = 26'h100;
        tick();
        continuar = 1'b0;
        desvio    = 1'b0;
        verifica("cont_desvio_parado", 32'(parado), 32'd0);
        verifica("cont_desvio_pc", 32'(pc), 32'd4);
        push_mem(26'd4);
        tick();
        verifica("final_spc", 32'(saida_pc), 32'd4);
        tick();
        pronto = 1'b0;
        verifica("sb_vazio", 32'(fila.size()), 32'd0);

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch stage that drives `pc` into the BIOS ROM (boot) and main instruction memory (run). It holds the instruction register that feeds decode through a valid/ready handshake. It sequences boot: it executes the BIOS from address 0, hands off to main memory when the BIOS reaches its halt, then stops fetching at a main-program halt. It also applies redirect (jump/branch) requests from execute.

Parameters:
PC_WIDTH, 26, width of program counter / instruction address
RESET_PC, 0, BIOS start address loaded on reset
HALT_OPCODE, 6'b011000, opcode field [31:26] recognised as halt

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
pc  out  PC_WIDTH  address to BIOS ROM and instruction memory (registered)
instrucao_bios  in  32  BIOS ROM data for `pc` (combinational ROM)
instrucao_mem  in  32  instruction memory data for `pc` (combinational)
modo_bios  out  1  1 = fetching from BIOS, 0 = from main memory
saida_instrucao  out  32  instruction register to decode
saida_pc  out  PC_WIDTH  address of the instruction in saida_instrucao
valido  out  1  saida_instrucao holds a valid instruction
pronto  in  1  decode accepts saida_instrucao this cycle
desvio  in  1  redirect request (single-cycle pulse)
alvo_desvio  in  PC_WIDTH  redirect target address
continuar  in  1  resume pulse after a main-program halt
parado  out  1  1 while in state HALT

Behaviour:
- States: BOOT (modo_bios=1), RUN (modo_bios=0), HALT (parado=1, modo_bios=0).
- Reset (reset=0, asynchronous) forces:
  - pc=RESET_PC, state BOOT, modo_bios=1, parado=0.
  - valido=0, saida_instrucao=0, saida_pc=0.
  - Reset is honoured mid-operation; any in-flight instruction is discarded.
- Source select: selected instruction = modo_bios ? instrucao_bios : instrucao_mem, taken from the current `pc`.
- Advance condition: avanca = (!valido || pronto) && state != HALT.
- Priority per cycle: reset > desvio > fetch.
- desvio=1 in BOOT or RUN:
  - pc<=alvo_desvio, valido<=0 (flush IR); state unchanged.
  - No fetch occurs that cycle.
  - In BOOT the target is interpreted in BIOS address space.
  - desvio is ignored in HALT.
- Fetch in BOOT with avanca=1:
  - Opcode != HALT_OPCODE: saida_instrucao<=instr, saida_pc<=pc, valido<=1, pc<=pc+1.
  - Opcode == HALT_OPCODE (boot hand-off): not delivered to decode; valido<=0 if pronto, otherwise the held IR stays; pc<=0; state<=RUN.
- Fetch in RUN with avanca=1:
  - Normal load as in BOOT: IR, saida_pc, valido<=1, pc<=pc+1.
  - If opcode == HALT_OPCODE, the halt is still delivered to decode (valido<=1), pc<=pc+1, and state<=HALT.
- HALT:
  - No fetch; pc frozen.
  - IR drains normally: valido<=0 once pronto=1.
  - continuar=1 -> RUN next cycle, fetching from the frozen pc.
- avanca=0 (valido=1, pronto=0): IR, saida_pc, valido and pc all hold (no instruction lost or duplicated).
- Latency: instruction at `pc` appears on saida_instrucao one clock after the fetch edge.
- Throughput: one instruction per cycle while pronto=1.
- pc+1 wraps modulo 2^PC_WIDTH (all ones -> 0).
- Simultaneous desvio and continuar in HALT: continuar wins, desvio is dropped.
- Out-of-range BIOS addresses are not checked here; the ROM returns its last word, which is a halt, so hand-off occurs.

Test Plan:
1. Reset then release with the 18-word BIOS image and pronto=1:
   - saida_pc sequence 0,1,2,… with valido=1 from the second clock.
   - At BIOS word 17 (halt): no valido for it, modo_bios falls to 0, pc=0.
2. Main memory words 0..3 = addi, addi, addi, halt (0x60000000), pronto=1:
   - saida_pc 0,1,2,3 delivered, halt valid.
   - parado=1 and pc=4 frozen for 10 cycles.
   - continuar pulse -> fetch resumes at 4.
3. Backpressure: hold pronto=0 for 5 cycles while valido=1 at saida_pc=5:
   - IR, saida_pc=5 and pc=6 stable.
   - On pronto=1 the sequence continues 6,7 with no skip or duplicate.
4. Redirect: in RUN at pc=9, pulse desvio with alvo_desvio=0x40:
   - Next cycle valido=0 and pc=0x40.
   - Following cycle saida_pc=0x40.
   - Same test in BOOT with target 15 -> BIOS words 15,16,17 then hand-off.
5. Wrap: force pc=0x3FFFFFF in RUN:
   - saida_pc=0x3FFFFFF, then pc=0.
6. Reset mid-run:
   - Assert reset asynchronously between clocks with valido=1: valido=0, pc=0 and modo_bios=1 immediately, without waiting for a clock edge.
   - After release the BIOS restarts at 0.
